// File: rtl/lcd_bus_arbiter_if.sv
// Writer-side handshake bundle for the shared character-LCD write bus.
`timescale 1ns/1ps
interface lcd_bus_arbiter_if;
  logic [2:0] req;
  logic [2:0] req_rs;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [7:0] req_data2;
  logic [2:0] lock;
  logic [2:0] ack;

  modport master (output req, req_rs, req_data0, req_data1, req_data2, lock, input ack);
  modport slave  (input req, req_rs, req_data0, req_data1, req_data2, lock, output ack);
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Shares the LCD write bus between three writers and owns all enable-pulse timing.
// Define LCD_ARB_INIT_EN to build the power-up wait and init command sequence.
`timescale 1ns/1ps
module lcd_bus_arbiter #(
  parameter int unsigned HOLD_CYC = 500,
  parameter int unsigned GAP_CYC  = 500,
  parameter int unsigned LONG_CYC = 2000,
  parameter int unsigned PWR_CYC  = 20000
) (
  input  logic                clk_1MHz,
  input  logic                rst,
  lcd_bus_arbiter_if.slave    bus,
  output logic                lcd_rs,
  output logic                lcd_rw,
  output logic                lcd_en,
  output logic [7:0]          lcd_data,
  output logic                busy,
  output logic                init_done
);

  // state | meaning: PWRUP power-up wait | INIT_HI/INIT_LO init byte high/low |
  // IDLE arbitrate | EN_HI/EN_LO writer byte high/low
  typedef enum logic [2:0] {PWRUP, INIT_HI, INIT_LO, IDLE, EN_HI, EN_LO} state_t;

  localparam logic [15:0] HOLD_T = 16'(HOLD_CYC - 1);
  localparam logic [15:0] GAP_T  = 16'(GAP_CYC - 1);
  localparam logic [15:0] LONG_T = 16'(LONG_CYC - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  ptr;
  logic [1:0]  owner;
  logic        owner_vld;
  logic [1:0]  cur;
  logic [2:0]  ack_q;

  logic        gnt_vld;
  logic [1:0]  gnt_idx;
  logic [7:0]  gnt_data;
  logic [1:0]  cand1;
  logic [1:0]  cand2;
  logic [15:0] low_last;

`ifdef LCD_ARB_INIT_EN
  localparam logic [15:0] PWR_T = 16'(PWR_CYC - 1);
  logic [1:0] init_idx;

  function automatic logic [7:0] init_rom(input logic [1:0] i);
    case (i)
      2'd0:    init_rom = 8'h38;
      2'd1:    init_rom = 8'h0C;
      2'd2:    init_rom = 8'h06;
      default: init_rom = 8'h01;
    endcase
  endfunction
`endif

  function automatic logic [1:0] nxt(input logic [1:0] i);
    nxt = (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign lcd_rw  = 1'b0;
  assign busy    = (state != IDLE);
  assign bus.ack = ack_q;

  // clear/home need the long settle time
  assign low_last = (!lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02)) ? LONG_T : GAP_T;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand1   = nxt(ptr);
    cand2   = nxt(cand1);
    if (owner_vld && bus.lock[owner]) begin
      gnt_vld = bus.req[owner];
      gnt_idx = owner;
    end else if (bus.req[cand1]) begin
      gnt_vld = 1'b1;
      gnt_idx = cand1;
    end else if (bus.req[cand2]) begin
      gnt_vld = 1'b1;
      gnt_idx = cand2;
    end else if (bus.req[ptr]) begin
      gnt_vld = 1'b1;
      gnt_idx = ptr;
    end
  end

  always_comb begin
    case (gnt_idx)
      2'd0:    gnt_data = bus.req_data0;
      2'd1:    gnt_data = bus.req_data1;
      default: gnt_data = bus.req_data2;
    endcase
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
`ifdef LCD_ARB_INIT_EN
      state    <= PWRUP;
      init_idx <= 2'd0;
`else
      state    <= IDLE;
`endif
      cnt       <= 16'd0;
      ptr       <= 2'd2;
      owner     <= 2'd0;
      owner_vld <= 1'b0;
      cur       <= 2'd0;
      ack_q     <= 3'b000;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_data  <= 8'h00;
      init_done <= 1'b0;
    end else begin
      case (state)
`ifdef LCD_ARB_INIT_EN
        PWRUP: begin
          if (cnt == PWR_T) begin
            state    <= INIT_HI;
            cnt      <= 16'd0;
            init_idx <= 2'd0;
            lcd_rs   <= 1'b0;
            lcd_data <= init_rom(2'd0);
            lcd_en   <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        INIT_HI: begin
          if (cnt == HOLD_T) begin
            state  <= INIT_LO;
            cnt    <= 16'd0;
            lcd_en <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        INIT_LO: begin
          if (cnt == low_last) begin
            cnt <= 16'd0;
            if (init_idx == 2'd3) begin
              state     <= IDLE;
              init_done <= 1'b1;
            end else begin
              state    <= INIT_HI;
              init_idx <= init_idx + 2'd1;
              lcd_data <= init_rom(init_idx + 2'd1);
              lcd_en   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        IDLE: begin
          init_done <= 1'b1;
          if (owner_vld && !bus.lock[owner])
            owner_vld <= 1'b0;
          if (gnt_vld) begin
            state    <= EN_HI;
            cnt      <= 16'd0;
            cur      <= gnt_idx;
            ptr      <= gnt_idx;
            lcd_rs   <= bus.req_rs[gnt_idx];
            lcd_data <= gnt_data;
            lcd_en   <= 1'b1;
          end
        end
        EN_HI: begin
          if (cnt == HOLD_T) begin
            state  <= EN_LO;
            cnt    <= 16'd0;
            lcd_en <= 1'b0;
            if (low_last == 16'd0)
              ack_q <= 3'b001 << cur;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        EN_LO: begin
          // ack is registered, so it is raised on the edge entering the last low cycle
          if (cnt == low_last) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            ack_q     <= 3'b000;
            owner     <= cur;
            owner_vld <= bus.lock[cur];
          end else begin
            cnt <= cnt + 16'd1;
            if (cnt + 16'd1 == low_last)
              ack_q <= 3'b001 << cur;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed self-checking bench for lcd_bus_arbiter with HOLD=4, GAP=4, LONG=10, PWR=20.
`timescale 1ns/1ps
module tb_lcd_bus_arbiter;
  logic       clk_1MHz = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs, lcd_rw, lcd_en, busy, init_done;
  logic [7:0] lcd_data;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  lcd_bus_arbiter_if w ();

  lcd_bus_arbiter #(.HOLD_CYC(4), .GAP_CYC(4), .LONG_CYC(10), .PWR_CYC(20)) dut (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .bus      (w),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data),
    .busy     (busy),
    .init_done(init_done)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  task automatic tick();
    @(negedge clk_1MHz);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_init();
    int n;
    int hi;
    int lo;
    n = 0;
    while (lcd_en !== 1'b1 && n < 100) begin tick(); n++; end
    check("pwr_wait", n, 20);
    for (int i = 0; i < 4; i++) begin
      check("init_data", lcd_data, rom[i]);
      check("init_rs", lcd_rs, 0);
      hi = 0;
      while (lcd_en === 1'b1 && hi < 100) begin tick(); hi++; end
      check("init_hi", hi, 4);
      check("init_done_pre", init_done, 0);
      lo = 0;
      while (lcd_en === 1'b0 && busy === 1'b1 && lo < 100) begin tick(); lo++; end
      check("init_lo", lo, (i == 3) ? 10 : 4);
    end
    check("init_idle", busy, 0);
    check("init_done_set", init_done, 1);
  endtask

  task automatic settle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
`ifdef LCD_ARB_INIT_EN
    run_init();
`else
    tick();
`endif
  endtask

  task automatic observe_byte(input int g, input logic rs, input logic [7:0] d, input int low,
                              input string tag, output int en_cyc, output int ack_cyc);
    int n;
    int hi;
    int lo;
    logic early_ack;
    n = 0;
    en_cyc = 0;
    ack_cyc = 0;
    while (lcd_en !== 1'b1 && n < 200) begin tick(); n++; end
    check({tag, "_en"}, lcd_en, 1);
    if (lcd_en !== 1'b1) return;
    en_cyc = cyc;
    check({tag, "_rs"}, lcd_rs, rs);
    check({tag, "_data"}, lcd_data, d);
    early_ack = 1'b0;
    hi = 0;
    while (lcd_en === 1'b1 && hi < 100) begin
      if (w.ack !== 3'b000) early_ack = 1'b1;
      tick();
      hi++;
    end
    check({tag, "_hi"}, hi, 4);
    lo = 0;
    while (lcd_en === 1'b0 && w.ack === 3'b000 && lo < 100) begin tick(); lo++; end
    check({tag, "_early_ack"}, early_ack, 0);
    check({tag, "_ack"}, w.ack, 3'b001 << g);
    check({tag, "_lo"}, lo + 1, low);
    check({tag, "_hold"}, {lcd_rs, lcd_data}, {rs, d});
    ack_cyc = cyc;
  endtask

  initial begin
    int t0, e, a, e2, a2, n;
    w.req = 3'b000;
    w.req_rs = 3'b000;
    w.req_data0 = 8'h00;
    w.req_data1 = 8'h00;
    w.req_data2 = 8'h00;
    w.lock = 3'b000;
    tick();
    tick();

    // reset values
    check("rst_en", lcd_en, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_data", lcd_data, 8'h00);
    check("rst_ack", w.ack, 3'b000);
    check("rst_init_done", init_done, 0);
`ifdef LCD_ARB_INIT_EN
    check("rst_busy", busy, 1);
`else
    check("rst_busy", busy, 0);
`endif
    rst = 1'b0;
    check("rel_init_done", init_done, 0);
`ifdef LCD_ARB_INIT_EN
    run_init();
`else
    tick();
    check("init_done_1cyc", init_done, 1);
    check("idle_busy", busy, 0);
`endif

    // single writer 1, data byte
    settle();
    w.req_rs = 3'b010;
    w.req_data1 = 8'h42;
    w.req = 3'b010;
    t0 = cyc;
    observe_byte(1, 1'b1, 8'h42, 4, "w1", e, a);
    check("w1_en_lat", e - t0, 1);
    check("w1_ack_lat", a - t0, 8);
    w.req = 3'b000;
    tick();
    check("w1_idle", busy, 0);
    check("w1_ack_width", w.ack, 3'b000);
    check("w1_data_kept", lcd_data, 8'h42);

    // round robin with all three requesting
    settle();
    w.req_rs = 3'b111;
    w.req_data0 = 8'h10;
    w.req_data1 = 8'h11;
    w.req_data2 = 8'h12;
    w.req = 3'b111;
    observe_byte(0, 1'b1, 8'h10, 4, "rr0", e, a);
    tick();
    check("rr0_ack_width", w.ack, 3'b000);
    observe_byte(1, 1'b1, 8'h11, 4, "rr1", e2, a2);
    check("rr1_regrant", e2 - a, 2);
    tick();
    check("rr1_ack_width", w.ack, 3'b000);
    observe_byte(2, 1'b1, 8'h12, 4, "rr2", e, a);
    tick();
    check("rr2_ack_width", w.ack, 3'b000);
    observe_byte(0, 1'b1, 8'h10, 4, "rr3", e, a);
    w.req = 3'b000;
    tick();

    // writer 2 locks the bus for three bytes while writer 0 waits
    settle();
    w.req_rs = 3'b101;
    w.req_data2 = 8'hA1;
    w.lock = 3'b100;
    w.req = 3'b100;
    tick();
    w.req_data0 = 8'h55;
    w.req = 3'b101;
    observe_byte(2, 1'b1, 8'hA1, 4, "lk1", e, a);
    w.req_data2 = 8'hA2;
    observe_byte(2, 1'b1, 8'hA2, 4, "lk2", e2, a2);
    check("lk2_regrant", e2 - a, 2);
    w.req_data2 = 8'hA3;
    tick();
    tick();
    w.lock = 3'b000;
    observe_byte(2, 1'b1, 8'hA3, 4, "lk3", e, a);
    w.req = 3'b001;
    observe_byte(0, 1'b1, 8'h55, 4, "lk_w0", e2, a2);
    check("lk_w0_next", e2 - a, 2);
    w.req = 3'b000;
    tick();

    // long low time only for clear/home commands
    settle();
    w.req_rs = 3'b000;
    w.req_data0 = 8'h01;
    w.req = 3'b001;
    observe_byte(0, 1'b0, 8'h01, 10, "clr_cmd", e, a);
    w.req = 3'b000;
    tick();
    w.req_rs = 3'b001;
    w.req = 3'b001;
    observe_byte(0, 1'b1, 8'h01, 4, "clr_dat", e, a);
    w.req = 3'b000;
    tick();
    w.req_rs = 3'b000;
    w.req_data0 = 8'h02;
    w.req = 3'b001;
    observe_byte(0, 1'b0, 8'h02, 10, "home_cmd", e, a);
    w.req = 3'b000;
    tick();
    w.req_data0 = 8'h03;
    w.req = 3'b001;
    observe_byte(0, 1'b0, 8'h03, 4, "cmd03", e, a);
    w.req = 3'b000;
    tick();

    // reset asserted during the enable-high phase
    settle();
    w.req_rs = 3'b010;
    w.req_data1 = 8'h77;
    w.req = 3'b010;
    n = 0;
    while (lcd_en !== 1'b1 && n < 50) begin tick(); n++; end
    check("rstmid_start", lcd_en, 1);
    tick();
    rst = 1'b1;
    #1;
    check("rstmid_en", lcd_en, 0);
    check("rstmid_ack", w.ack, 3'b000);
    check("rstmid_data", lcd_data, 8'h00);
    w.req = 3'b000;
    tick();
    check("rstmid_ack2", w.ack, 3'b000);
    rst = 1'b0;
`ifdef LCD_ARB_INIT_EN
    check("rstmid_busy", busy, 1);
    run_init();
`else
    tick();
    check("rstmid_idle", busy, 0);
    tick();
    check("rstmid_en_low", lcd_en, 0);
    check("rstmid_ack3", w.ack, 3'b000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
